// File: rtl/mdu_issue_arb.sv
// ----------------------------------------------------------------------------
// mdu_issue_arb
//
// Shares the single multiply/divide unit among NUM_REQ reservation-station
// issue ports. Each cycle one ready requester is picked in round-robin order
// and its operands are captured into a one-entry issue register. That
// register drives the MDU request and holds steady until the MDU takes it.
//
// Optional build macro: MDU_ISSUE_AGE_PRIO_EN
//   Defined   : adds input rob_head. The valid port whose ROB index is oldest
//               relative to rob_head wins. Ties go to round-robin order.
//   Undefined : pure round-robin, and there is no rob_head port.
//
// Ports
//   clk, rst_n       clock, asynchronous active-low reset
//   flush            discard the held op and block grants this cycle
//   req_vld/req_rdy  per-port issue handshake (req_rdy is one-hot or zero)
//   req_opc/src1/src2/tag/inst_id
//                    per-port op fields, packed with port i at slice i
//   rob_head         ROB head index (only with MDU_ISSUE_AGE_PRIO_EN)
//   mdu_req/mdu_rdy  held-op handshake toward the MDU
//   mdu_opc/src1/src2/tag/inst_id
//                    held-op fields
//   stall_cnt        saturating count of cycles with mdu_req=1, mdu_rdy=0
//
// Handshake rules (both interfaces):
//   A transfer happens on a rising clk edge where valid and ready are both 1.
//   A requester keeps valid and its fields stable until that transfer.
//   Ready may depend combinationally on the other side's ready: req_rdy
//   depends on mdu_rdy. Valid never depends on ready.
//   mdu_req and the mdu_* fields come straight from registers.
//
// The only state is the valid bit of the issue register, the round-robin
// pointer and the stall counter. There is no multi-state FSM to expose.
// ----------------------------------------------------------------------------
module mdu_issue_arb #(
    parameter int NUM_REQ   = 4,
    parameter int XLEN      = 32,
    parameter int TAG_W     = 6,
    parameter int ROB_DEPTH = 16,
    parameter int ROB_PTR_W = $clog2(ROB_DEPTH)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic [NUM_REQ-1:0]           req_vld,
    output logic [NUM_REQ-1:0]           req_rdy,
    input  logic [NUM_REQ*3-1:0]         req_opc,
    input  logic [NUM_REQ*XLEN-1:0]      req_src1,
    input  logic [NUM_REQ*XLEN-1:0]      req_src2,
    input  logic [NUM_REQ*TAG_W-1:0]     req_tag,
    input  logic [NUM_REQ*ROB_PTR_W-1:0] req_inst_id,
`ifdef MDU_ISSUE_AGE_PRIO_EN
    input  logic [ROB_PTR_W-1:0]         rob_head,
`endif
    output logic                         mdu_req,
    input  logic                         mdu_rdy,
    output logic [2:0]                   mdu_opc,
    output logic [XLEN-1:0]              mdu_src1,
    output logic [XLEN-1:0]              mdu_src2,
    output logic [TAG_W-1:0]             mdu_tag,
    output logic [ROB_PTR_W-1:0]         mdu_inst_id,
    output logic [15:0]                  stall_cnt
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] win;
    logic [PTR_W-1:0] rr_next;
    logic             any_vld;
    logic             load_en;
    logic             accept;
    logic             hold;

    // Scratch variables for the winner search.
    int               scan_idx;
`ifdef MDU_ISSUE_AGE_PRIO_EN
    int               cur_age;
    int               best_age;
`else
    logic             found;
`endif

    // The issue register can take a new op when it is empty or when its
    // current op is leaving this cycle. A flush blocks loading outright.
    assign any_vld = |req_vld;
    assign load_en = !flush && (!mdu_req || mdu_rdy);
    assign accept  = load_en && any_vld;
    assign hold    = mdu_req && !mdu_rdy;

    // ------------------------------------------------------------------------
    // Winner search: scan from rr_ptr upward and wrap modulo NUM_REQ.
    // ------------------------------------------------------------------------
`ifdef MDU_ISSUE_AGE_PRIO_EN
    // Age is the distance from the ROB head, so the oldest op has the
    // smallest age. The comparison is strict, so among equal ages the first
    // port reached in round-robin order keeps the win.
    always_comb begin
        win      = '0;
        scan_idx = 0;
        cur_age  = 0;
        best_age = ROB_DEPTH;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = (int'(rr_ptr) + k) % NUM_REQ;
            cur_age  = int'(req_inst_id[scan_idx*ROB_PTR_W +: ROB_PTR_W])
                     - int'(rob_head);
            if (cur_age < 0) begin
                cur_age = cur_age + ROB_DEPTH;
            end
            if (req_vld[scan_idx] && (cur_age < best_age)) begin
                best_age = cur_age;
                win      = PTR_W'(scan_idx);
            end
        end
    end
`else
    always_comb begin
        win      = '0;
        scan_idx = 0;
        found    = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (!found && req_vld[scan_idx]) begin
                found = 1'b1;
                win   = PTR_W'(scan_idx);
            end
        end
    end
`endif

    // Next pointer sits just past the winner. The compare handles
    // non-power-of-two NUM_REQ.
    assign rr_next = (win == PTR_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;

    // The grant is combinational. It is forced low while reset is asserted,
    // so no port sees a transfer that the register cannot record.
    always_comb begin
        req_rdy = '0;
        if (rst_n && accept) begin
            req_rdy[win] = 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Issue register, round-robin pointer and stall counter.
    // Priority: reset > flush > accept / hold / drain.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdu_req     <= 1'b0;
            mdu_opc     <= '0;
            mdu_src1    <= '0;
            mdu_src2    <= '0;
            mdu_tag     <= '0;
            mdu_inst_id <= '0;
            rr_ptr      <= '0;
        end else if (flush) begin
            // The held op is dropped even if the MDU takes it this cycle.
            // Squashing it downstream is handled outside this block.
            mdu_req <= 1'b0;
        end else if (accept) begin
            mdu_req     <= 1'b1;
            mdu_opc     <= req_opc[int'(win)*3 +: 3];
            mdu_src1    <= req_src1[int'(win)*XLEN +: XLEN];
            mdu_src2    <= req_src2[int'(win)*XLEN +: XLEN];
            mdu_tag     <= req_tag[int'(win)*TAG_W +: TAG_W];
            mdu_inst_id <= req_inst_id[int'(win)*ROB_PTR_W +: ROB_PTR_W];
            rr_ptr      <= rr_next;
        end else if (load_en) begin
            // Drain with nothing to refill. The fields keep their stale
            // contents, which no one reads while mdu_req is low.
            mdu_req <= 1'b0;
        end
        // Otherwise hold: every output stays as it is.
    end

    // A flush cycle is not counted as a stall, even when the MDU is busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (!flush && hold && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_mdu_issue_arb.sv
module tb_mdu_issue_arb;

  localparam int N     = 4;
  localparam int XLEN  = 32;
  localparam int TAG_W = 6;
  localparam int DEPTH = 16;
  localparam int RW    = 4;
  localparam int OPW   = 3 + 2*XLEN + TAG_W + RW;
  localparam int SAT_LOOP = 65540;

  logic                clk;
  logic                rst_n;
  logic                flush;
  logic [N-1:0]        req_vld;
  logic [N-1:0]        req_rdy;
  logic [N*3-1:0]      req_opc;
  logic [N*XLEN-1:0]   req_src1;
  logic [N*XLEN-1:0]   req_src2;
  logic [N*TAG_W-1:0]  req_tag;
  logic [N*RW-1:0]     req_inst_id;
`ifdef MDU_ISSUE_AGE_PRIO_EN
  logic [RW-1:0]       rob_head;
`endif
  logic                mdu_req;
  logic                mdu_rdy;
  logic [2:0]          mdu_opc;
  logic [XLEN-1:0]     mdu_src1;
  logic [XLEN-1:0]     mdu_src2;
  logic [TAG_W-1:0]    mdu_tag;
  logic [RW-1:0]       mdu_inst_id;
  logic [15:0]         stall_cnt;

  mdu_issue_arb #(
    .NUM_REQ(N), .XLEN(XLEN), .TAG_W(TAG_W), .ROB_DEPTH(DEPTH), .ROB_PTR_W(RW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .req_vld(req_vld), .req_rdy(req_rdy),
    .req_opc(req_opc), .req_src1(req_src1), .req_src2(req_src2),
    .req_tag(req_tag), .req_inst_id(req_inst_id),
`ifdef MDU_ISSUE_AGE_PRIO_EN
    .rob_head(rob_head),
`endif
    .mdu_req(mdu_req), .mdu_rdy(mdu_rdy),
    .mdu_opc(mdu_opc), .mdu_src1(mdu_src1), .mdu_src2(mdu_src2),
    .mdu_tag(mdu_tag), .mdu_inst_id(mdu_inst_id),
    .stall_cnt(stall_cnt)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard and reference model state ----------------
  logic [OPW-1:0] exp_q[$];
  logic           m_req;
  int             m_rr;
  logic [15:0]    m_stall;
  logic [N-1:0]   obs_rdy;
  int             n_cmp;
  int             n_err;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [OPW-1:0] pack_port(input int i);
    return {req_opc[i*3 +: 3], req_src1[i*XLEN +: XLEN], req_src2[i*XLEN +: XLEN],
            req_tag[i*TAG_W +: TAG_W], req_inst_id[i*RW +: RW]};
  endfunction

  function automatic logic [OPW-1:0] pack_dut();
    return {mdu_opc, mdu_src1, mdu_src2, mdu_tag, mdu_inst_id};
  endfunction

  // Expected winner: oldest valid port (age mode) or the first valid port
  // in round-robin order from rr. Returns -1 when nothing is valid.
  function automatic int model_win(input logic [N-1:0] vld, input int rr);
    int best;
    int best_age;
    best = -1;
    best_age = 1 << 30;
    for (int k = 0; k < N; k++) begin
      int idx;
      int a;
      idx = (rr + k) % N;
`ifdef MDU_ISSUE_AGE_PRIO_EN
      a = (int'(req_inst_id[idx*RW +: RW]) - int'(rob_head) + DEPTH) % DEPTH;
`else
      a = 0;
`endif
      if (vld[idx] && a < best_age) begin
        best_age = a;
        best = idx;
      end
    end
    return best;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_in(input logic [N-1:0] v, input logic r, input logic f);
    req_vld = v;
    mdu_rdy = r;
    flush   = f;
    for (int i = 0; i < N; i++) begin
      req_opc[i*3 +: 3]             = 3'($urandom_range(0, 7));
      req_src1[i*XLEN +: XLEN]      = $urandom;
      req_src2[i*XLEN +: XLEN]      = $urandom;
      req_tag[i*TAG_W +: TAG_W]     = TAG_W'($urandom_range(0, 63));
      req_inst_id[i*RW +: RW]       = RW'($urandom_range(0, DEPTH-1));
    end
  endtask

  // Checks one cycle at the falling edge, then advances the model across
  // the rising edge. Inputs are driven 1 time unit after each rising edge.
  task automatic cycle();
    int           w;
    logic [N-1:0] e_rdy;
    logic         le;
    logic         old_req;
    @(negedge clk);
    le = !flush && (!m_req || mdu_rdy);
    w = model_win(req_vld, m_rr);
    e_rdy = '0;
    if (le && w >= 0) e_rdy[w] = 1'b1;
    obs_rdy = req_rdy;
    check("req_rdy", 128'(req_rdy), 128'(e_rdy));
    check("mdu_req", 128'(mdu_req), 128'(m_req));
    check("stall_cnt", 128'(stall_cnt), 128'(m_stall));
    if (m_req) begin
      check("sb_depth", 128'(exp_q.size()), 128'(1));
      if (exp_q.size() != 0) check("mdu_op", 128'(pack_dut()), 128'(exp_q[0]));
    end
    old_req = m_req;
    if (m_req && (mdu_rdy || flush)) void'(exp_q.pop_front());
    if (!flush && old_req && !mdu_rdy && m_stall != 16'hFFFF) m_stall++;
    if (flush) m_req = 1'b0;
    else if (e_rdy != '0) begin
      exp_q.push_back(pack_port(w));
      m_req = 1'b1;
      m_rr = (w + 1) % N;
    end else if (le) m_req = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input logic [N-1:0] v, input logic r, input logic f);
    set_in(v, r, f);
    cycle();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_cmp = 0;
    n_err = 0;
    m_req = 1'b0;
    m_rr = 0;
    m_stall = '0;
    rst_n = 1'b0;
`ifdef MDU_ISSUE_AGE_PRIO_EN
    rob_head = '0;
`endif
    set_in(4'b1111, 1'b1, 1'b0);
    #3;
    check("rst_mdu_req", 128'(mdu_req), 128'(0));
    check("rst_stall", 128'(stall_cnt), 128'(0));
    check("rst_req_rdy", 128'(req_rdy), 128'(0));
    check("rst_fields", 128'(pack_dut()), 128'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Round robin, all ports requesting, MDU always ready.
    for (int i = 0; i < 6; i++) begin
      run(4'b1111, 1'b1, 1'b0);
      check("rr_order", 128'(obs_rdy), 128'(1 << (i % N)));
    end

    // Backpressure for 5 cycles, then port 2 alone.
    for (int i = 0; i < 5; i++) run(4'b1111, 1'b0, 1'b0);
    check("stall_5", 128'(stall_cnt), 128'(5));
    run(4'b0100, 1'b1, 1'b0);
    check("bp_grant2", 128'(obs_rdy), 128'(4'b0100));

    // Wrap/skip: rr_ptr is 3 and only port 1 requests.
    run(4'b0010, 1'b1, 1'b0);
    check("wrap_grant1", 128'(obs_rdy), 128'(4'b0010));
    run(4'b1111, 1'b1, 1'b0);
    check("wrap_next2", 128'(obs_rdy), 128'(4'b0100));

    // Drain, then flush during a hold.
    run(4'b0000, 1'b1, 1'b0);
    run(4'b0001, 1'b1, 1'b0);
    run(4'b0001, 1'b0, 1'b1);
    check("flush_no_grant", 128'(obs_rdy), 128'(0));
    check("flush_drop", 128'(mdu_req), 128'(0));
    run(4'b0001, 1'b0, 1'b0);
    check("post_flush_grant0", 128'(obs_rdy), 128'(4'b0001));
    run(4'b1111, 1'b1, 1'b1);
    run(4'b0000, 1'b1, 1'b0);

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      run(4'($urandom_range(0, 15)), $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0);
    end

    // Stall counter saturation.
    run(4'b1111, 1'b1, 1'b0);
    set_in(4'b1111, 1'b0, 1'b0);
    repeat (SAT_LOOP) @(posedge clk);
    #1;
    m_stall = 16'hFFFF;
    cycle();
    cycle();
    check("stall_sat", 128'(stall_cnt), 128'(16'hFFFF));

    // Asynchronous reset mid-cycle while an op is held.
    run(4'b1111, 1'b1, 1'b0);
    check("pre_rst_req", 128'(mdu_req), 128'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_mdu_req", 128'(mdu_req), 128'(0));
    check("arst_stall", 128'(stall_cnt), 128'(0));
    check("arst_req_rdy", 128'(req_rdy), 128'(0));
    m_req = 1'b0;
    m_rr = 0;
    m_stall = '0;
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run(4'b1111, 1'b1, 1'b0);
    check("arst_rr0", 128'(obs_rdy), 128'(4'b0001));

`ifdef MDU_ISSUE_AGE_PRIO_EN
    set_in(4'b1111, 1'b1, 1'b0);
    rob_head = 4'd14;
    req_inst_id = {4'd1, 4'd0, 4'd15, 4'd3};
    cycle();
    check("age_head14", 128'(obs_rdy), 128'(4'b0010));
    set_in(4'b1111, 1'b1, 1'b0);
    rob_head = 4'd0;
    req_inst_id = {4'd1, 4'd0, 4'd15, 4'd3};
    cycle();
    check("age_head0", 128'(obs_rdy), 128'(4'b0100));
`endif

    run(4'b0000, 1'b1, 1'b0);
    run(4'b0000, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mdu_issue_arb.md
Name: mdu_issue_arb

Overview:
Arbiter/scheduler that shares the single multiply/divide unit among NUM_REQ reservation-station issue ports. Picks one ready requester per cycle (round-robin) and captures its operands into a one-entry issue register. That register drives the MDU request handshake and holds stable until the MDU accepts it. Sits between the MDU reservation stations and the MDU; supports pipeline flush.

Parameters:
NUM_REQ, 4, number of requesting issue ports (>=2)
XLEN, 32, operand width
TAG_W, 6, physical register tag width
ROB_DEPTH, 16, ROB entries
ROB_PTR_W, $clog2(ROB_DEPTH), ROB index width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
flush  in  1  discard held op and block grants this cycle
req_vld  in  NUM_REQ  per-port issue request
req_rdy  out  NUM_REQ  per-port accept (one-hot or zero)
req_opc  in  NUM_REQ*3  per-port mdu opcode (mul..remu encoding)
req_src1  in  NUM_REQ*XLEN  per-port operand 1
req_src2  in  NUM_REQ*XLEN  per-port operand 2
req_tag  in  NUM_REQ*TAG_W  per-port destination tag
req_inst_id  in  NUM_REQ*ROB_PTR_W  per-port ROB index
mdu_req  out  1  held op valid to MDU
mdu_rdy  in  1  MDU accepts held op
mdu_opc / mdu_src1 / mdu_src2 / mdu_tag / mdu_inst_id  out  3/XLEN/XLEN/TAG_W/ROB_PTR_W  held op fields
stall_cnt  out  16  cycles with mdu_req=1 and mdu_rdy=0, saturating

Behaviour:
- Reset (async, rst_n=0): mdu_req=0, all mdu_* fields=0, rr_ptr=0, stall_cnt=0. req_rdy is combinational and reads 0 while in reset.
- load_en = !flush & (!mdu_req | mdu_rdy).
- Arbitration:
  - Search req_vld starting at index rr_ptr, ascending, wrapping modulo NUM_REQ; the first set bit wins.
  - req_rdy[win] = load_en & |req_vld; all other req_rdy bits are 0.
  - req_rdy depends combinationally on mdu_rdy.
- Accept (load_en & |req_vld):
  - Next cycle: mdu_req=1 and the winner's fields are registered.
  - rr_ptr <= (win+1) mod NUM_REQ, wrapping from NUM_REQ-1 to 0.
- Latency: one cycle from req_vld/req_rdy handshake to mdu_req.
- Back-to-back: when mdu_req & mdu_rdy and a new request is present in the same cycle, the register reloads with no bubble. This gives 1 op/cycle when the MDU is ready.
- Drain without refill: mdu_req & mdu_rdy & !|req_vld -> mdu_req=0 next cycle. Fields keep their old value (don't care).
- Hold: mdu_req & !mdu_rdy -> all mdu_* outputs stable, req_rdy=0, rr_ptr unchanged, stall_cnt increments and saturates at 0xFFFF.
- Flush:
  - Next cycle mdu_req=0, regardless of mdu_rdy.
  - No grant that cycle; rr_ptr unchanged.
  - stall_cnt unchanged.
- Flush together with mdu_rdy: the MDU still takes the op that cycle (the handshake completes). Squashing it in the MDU/ROB is the caller's job.
- Priority of simultaneous events: reset > flush > accept/hold.
- Fairness: with all ports continuously requesting, each port wins exactly once per NUM_REQ accepts.
- No state machine beyond the valid bit. A request must be held by the RS until its req_rdy is seen.

Optional Feature:
Macro MDU_ISSUE_AGE_PRIO_EN.
- Defined:
  - Adds input rob_head [ROB_PTR_W].
  - age[i] = (req_inst_id[i] - rob_head) mod ROB_DEPTH.
  - The valid port with the smallest age wins. Ties are broken by round-robin order from rr_ptr.
  - rr_ptr still updates as above.
- Undefined: no rob_head port; pure round-robin as described.

Test Plan:
- Reset: rst_n=0 asynchronously mid-cycle while mdu_req=1 -> mdu_req=0 immediately, rr_ptr=0, stall_cnt=0.
- Round-robin: req_vld=4'b1111 continuously, mdu_rdy=1 -> grants in order 0,1,2,3,0; mdu_req stays 1 with no bubbles; mdu_src1 matches each port's value one cycle later.
- Backpressure: mdu_req=1, mdu_rdy=0 for 5 cycles -> mdu_* stable, req_rdy=0, stall_cnt=5. Then mdu_rdy=1 with req_vld=4'b0100 -> port 2 is granted the same cycle.
- Wrap/skip: rr_ptr=3, req_vld=4'b0010 -> port 1 is granted and rr_ptr becomes 2.
- Flush: mdu_req=1, mdu_rdy=0, flush=1, req_vld=4'b0001 -> req_rdy=0, mdu_req=0 next cycle. The following cycle port 0 is granted.
- Age priority (macro on): rob_head=14, inst_ids {3,15,0,1}, all valid -> port 1 (age 1) wins; with rob_head=0 -> port 2 wins.
